drp_responder: RTL and testbench
================================

DRP_RESPONDER -- requirements
Module: drp_responder

Interface
REQ-001 SHALL have parameter pNUM_REGS, default 32, meaning number of implemented 16-bit registers (legal 1..127).
REQ-002 SHALL have parameter pLATENCY, default 3, meaning cycles from accepted request to drp_drdy (legal 1..15).
REQ-003 SHALL have parameter pRESET_VAL, default 16'h0000, meaning reset value of every register.
REQ-004 SHALL have port clk_usb, input, 1, meaning sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, meaning reset, synchronous, active-high.
REQ-006 SHALL have port drp_addr, input, 7, meaning request register address.
REQ-007 SHALL have port drp_den, input, 1, meaning request strobe, one cycle per request.
REQ-008 SHALL have port drp_dwe, input, 1, meaning write qualifier, sampled only with drp_den.
REQ-009 SHALL have port drp_din, input, 16, meaning write data.
REQ-010 SHALL have port drp_dout, output, 16, meaning read data.
REQ-011 SHALL have port drp_drdy, output, 1, meaning one-cycle completion pulse.
REQ-012 SHALL have port status_i, input, 16, meaning read-only status word at address 7'h7F.
REQ-013 SHALL have port cfg_o, output, pNUM_REGS*16, meaning flat register bank, register k at bits [k*16 +: 16].
REQ-014 SHALL have port wr_strobe_o, output, 1, meaning one-cycle pulse on committed register write.
REQ-015 SHALL have port wr_addr_o, output, 7, meaning address of last committed write.
REQ-016 SHALL have port err_o, output, 2, meaning sticky errors: bit0 overlap, bit1 bad address.
REQ-017 SHALL have port err_clear_i, input, 1, meaning clears err_o.

Function
REQ-018 SHALL implement states IDLE, WAIT, DONE; drp_drdy high exactly in DONE.
REQ-019 SHALL accept a request when drp_den=1 in IDLE or DONE, capturing drp_addr, drp_dwe, drp_din on that edge.
REQ-020 SHALL, for a request accepted at cycle N, assert drp_drdy for exactly cycle N+pLATENCY (pLATENCY=1: straight to DONE).
REQ-021 SHALL, in DONE with no new drp_den, return to IDLE; with drp_den, accept and go to WAIT (or DONE if pLATENCY=1), giving back-to-back throughput of one request per pLATENCY cycles.
REQ-022 SHALL ignore drp_den in WAIT (no capture, no extra drdy) and set err_o[0].
REQ-023 SHALL ignore drp_dwe and drp_din when drp_den=0.
REQ-024 SHALL commit writes (addr < pNUM_REGS) on the edge entering DONE, so cfg_o updates in the drdy cycle.
REQ-025 SHALL pulse wr_strobe_o coincident with drp_drdy for committed writes only, updating wr_addr_o on the same edge.
REQ-026 SHALL load drp_dout on the edge entering DONE for reads: register value (addr < pNUM_REGS), status_i sampled that edge (addr 7'h7F), else 16'h0000.
REQ-027 SHALL hold drp_dout after a write and between transactions at the last read value.
REQ-028 SHALL ignore writes to 7'h7F without error.
REQ-029 SHALL, for addr >= pNUM_REGS and != 7'h7F, still pulse drp_drdy, not modify registers, not pulse wr_strobe_o, and set err_o[1].
REQ-030 SHALL clear err_o on err_clear_i; a same-cycle set event wins over clear.
REQ-031 SHALL count latency with a 4-bit down-counter, no wrap; counter unused outside WAIT.

Reset
REQ-032 SHALL on reset_i: state IDLE, drp_drdy=0, drp_dout=0, wr_strobe_o=0, wr_addr_o=0, err_o=0, all registers=pRESET_VAL.
REQ-033 SHALL abort any in-flight request on reset_i: no drdy, no write commit; reset dominates drp_den.

Verification
REQ-034 Write 16'hA5C3 to addr 5 at cycle N (pLATENCY=3) -> drp_drdy and wr_strobe_o high only at N+3, wr_addr_o=5, cfg_o[95:80]=16'hA5C3.
REQ-035 Read addr 5 after above -> drp_dout=16'hA5C3 at drdy; read 7'h7F with status_i=16'h1234 -> drp_dout=16'h1234.
REQ-036 Second drp_den at N+1 -> ignored, single drdy at N+3, err_o=2'b01; err_clear_i -> err_o=0.
REQ-037 Write addr 40 (pNUM_REGS=32) -> drdy at N+3, no wr_strobe_o, cfg_o unchanged, err_o[1]=1; read addr 40 -> drp_dout=0.
REQ-038 drp_den in drdy cycle -> accepted, next drdy 3 cycles later; reset_i at N+1 of a write -> no drdy, register keeps pRESET_VAL.

Source files
------------

// File: rtl/drp_responder.sv
// drp_responder: DRP-style register slave with fixed response latency.
//   clk_usb, reset_i          : clock, synchronous active-high reset
//   drp_addr/den/dwe/din      : request (one-cycle strobe, write qualifier, data)
//   drp_dout, drp_drdy        : read data (held between reads), completion pulse
//   status_i                  : read-only status word at address 7'h7F
//   cfg_o                     : flat register bank, register k at [k*16 +: 16]
//   wr_strobe_o, wr_addr_o    : committed-write pulse and address of last write
//   err_o, err_clear_i        : sticky errors {bad address, overlap}, clear
module drp_responder #(
  parameter int unsigned pNUM_REGS  = 32,
  parameter int unsigned pLATENCY   = 3,
  parameter logic [15:0] pRESET_VAL = 16'h0000
) (
  input  logic                     clk_usb,
  input  logic                     reset_i,
  input  logic [6:0]               drp_addr,
  input  logic                     drp_den,
  input  logic                     drp_dwe,
  input  logic [15:0]              drp_din,
  output logic [15:0]              drp_dout,
  output logic                     drp_drdy,
  input  logic [15:0]              status_i,
  output logic [pNUM_REGS*16-1:0]  cfg_o,
  output logic                     wr_strobe_o,
  output logic [6:0]               wr_addr_o,
  output logic [1:0]               err_o,
  input  logic                     err_clear_i
);

  localparam int unsigned AW          = (pNUM_REGS > 1) ? $clog2(pNUM_REGS) : 1;
  localparam logic [6:0]  STATUS_ADDR = 7'h7F;
  // WAIT spans pLATENCY-1 cycles; the counter expires at zero.
  localparam logic [3:0]  CNT_LOAD    = (pLATENCY >= 2) ? 4'(pLATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept_c, overlap_c, enter_done_c;

  logic [6:0]  req_addr;
  logic        req_we;
  logic [15:0] req_din;

  logic [6:0]  cmt_addr_c;
  logic        cmt_we_c;
  logic [15:0] cmt_din_c;
  logic        in_range_c, bad_addr_c;

  logic [15:0] regs [pNUM_REGS];

  // State register
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, latency counter and accept/overlap decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_c  = 1'b0;
    overlap_c = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (drp_den) begin
          accept_c = 1'b1;
          if (pLATENCY == 1) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        overlap_c = drp_den;
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      req_addr <= 7'd0;
      req_we   <= 1'b0;
      req_din  <= 16'd0;
    end else if (accept_c) begin
      req_addr <= drp_addr;
      req_we   <= drp_dwe;
      req_din  <= drp_din;
    end
  end

  // With single-cycle latency the commit happens on the accept edge, so use live inputs
  assign cmt_addr_c   = accept_c ? drp_addr : req_addr;
  assign cmt_we_c     = accept_c ? drp_dwe  : req_we;
  assign cmt_din_c    = accept_c ? drp_din  : req_din;
  assign enter_done_c = (state_nxt == DONE);
  assign in_range_c   = (cmt_addr_c < 7'(pNUM_REGS));
  assign bad_addr_c   = enter_done_c && !in_range_c && (cmt_addr_c != STATUS_ADDR);

  // Commit, read data, completion pulses and sticky errors
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      drp_drdy    <= 1'b0;
      drp_dout    <= 16'h0000;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= 7'd0;
      err_o       <= 2'b00;
      for (int k = 0; k < int'(pNUM_REGS); k++) regs[k] <= pRESET_VAL;
    end else begin
      drp_drdy    <= enter_done_c;
      wr_strobe_o <= 1'b0;
      if (enter_done_c) begin
        if (in_range_c) begin
          if (cmt_we_c) begin
            regs[cmt_addr_c[AW-1:0]] <= cmt_din_c;
            wr_strobe_o              <= 1'b1;
            wr_addr_o                <= cmt_addr_c;
          end else begin
            drp_dout <= regs[cmt_addr_c[AW-1:0]];
          end
        end else if (cmt_addr_c == STATUS_ADDR) begin
          if (!cmt_we_c) drp_dout <= status_i;
        end else if (!cmt_we_c) begin
          drp_dout <= 16'h0000;
        end
      end
      // A set event in the same cycle as a clear wins
      err_o <= (err_clear_i ? 2'b00 : err_o) | {bad_addr_c, overlap_c};
    end
  end

  // Flatten register bank
  for (genvar k = 0; k < int'(pNUM_REGS); k++) begin : g_cfg
    assign cfg_o[k*16 +: 16] = regs[k];
  end

endmodule

// File: tb/tb_drp_responder.sv
// Self-checking bench for drp_responder: directed scenarios plus random traffic
// compared every cycle against a transaction-level model (requests stamped with
// their completion edge).
module tb_drp_responder;

  localparam int unsigned NREG = 32;
  localparam int unsigned LAT  = 3;
  localparam logic [15:0] RVAL = 16'h5A01;

  logic              clk_usb;
  logic              reset_i;
  logic [6:0]        drp_addr;
  logic              drp_den;
  logic              drp_dwe;
  logic [15:0]       drp_din;
  logic [15:0]       drp_dout;
  logic              drp_drdy;
  logic [15:0]       status_i;
  logic [NREG*16-1:0] cfg_o;
  logic              wr_strobe_o;
  logic [6:0]        wr_addr_o;
  logic [1:0]        err_o;
  logic              err_clear_i;

  int checks = 0;
  int errors = 0;

  drp_responder #(.pNUM_REGS(NREG), .pLATENCY(LAT), .pRESET_VAL(RVAL)) dut (
    .clk_usb(clk_usb), .reset_i(reset_i), .drp_addr(drp_addr), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_din(drp_din), .drp_dout(drp_dout), .drp_drdy(drp_drdy),
    .status_i(status_i), .cfg_o(cfg_o), .wr_strobe_o(wr_strobe_o),
    .wr_addr_o(wr_addr_o), .err_o(err_o), .err_clear_i(err_clear_i)
  );

  initial clk_usb = 1'b0;
  always #5 clk_usb = ~clk_usb;

  // Reference model state
  logic [15:0] m_regs [NREG];
  logic [15:0] m_dout;
  logic        m_drdy, m_strobe;
  logic [6:0]  m_waddr;
  logic [1:0]  m_err;
  bit          pend_v;
  logic [6:0]  pend_addr;
  logic        pend_we;
  logic [15:0] pend_din;
  int          pend_edge;
  int          edge_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge of the model, using the inputs as they stood at that edge
  task automatic model_edge();
    logic [1:0] set;
    bit busy;
    set = 2'b00;
    if (reset_i) begin
      pend_v = 0; m_drdy = 0; m_strobe = 0; m_dout = 16'h0; m_waddr = 7'h0; m_err = 2'b00;
      for (int k = 0; k < int'(NREG); k++) m_regs[k] = RVAL;
    end else begin
      busy = pend_v;
      m_drdy = 0;
      m_strobe = 0;
      if (drp_den) begin
        if (busy) set[0] = 1'b1;
        else begin
          pend_v = 1; pend_addr = drp_addr; pend_we = drp_dwe; pend_din = drp_din;
          pend_edge = edge_no + int'(LAT) - 1;
        end
      end
      if (pend_v && pend_edge == edge_no) begin
        pend_v = 0;
        m_drdy = 1;
        if (int'(pend_addr) < int'(NREG)) begin
          if (pend_we) begin
            m_regs[int'(pend_addr)] = pend_din; m_strobe = 1; m_waddr = pend_addr;
          end else m_dout = m_regs[int'(pend_addr)];
        end else if (pend_addr == 7'h7F) begin
          if (!pend_we) m_dout = status_i;
        end else begin
          set[1] = 1'b1;
          if (!pend_we) m_dout = 16'h0000;
        end
      end
      m_err = (err_clear_i ? 2'b00 : m_err) | set;
    end
  endtask

  // Drive one cycle of inputs, clock, update model, compare all outputs
  task automatic step(input logic den, input logic we, input logic [6:0] a,
                      input logic [15:0] d, input logic rst, input logic clr);
    drp_den = den; drp_dwe = we; drp_addr = a; drp_din = d;
    reset_i = rst; err_clear_i = clr;
    status_i = 16'($urandom);
    @(posedge clk_usb);
    edge_no++;
    model_edge();
    #1;
    chk("drdy", 32'(drp_drdy), 32'(m_drdy));
    chk("dout", 32'(drp_dout), 32'(m_dout));
    chk("wr_strobe", 32'(wr_strobe_o), 32'(m_strobe));
    chk("wr_addr", 32'(wr_addr_o), 32'(m_waddr));
    chk("err", 32'(err_o), 32'(m_err));
    for (int k = 0; k < int'(NREG); k++) chk($sformatf("cfg%0d", k), 32'(cfg_o[k*16 +: 16]), 32'(m_regs[k]));
  endtask

  task automatic idle(); step(1'b0, 1'b0, 7'h0, 16'h0, 1'b0, 1'b0); endtask

  initial begin
    drp_den = 0; drp_dwe = 0; drp_addr = 0; drp_din = 0; reset_i = 1; err_clear_i = 0; status_i = 0;

    // Reset with noise on the request lines: reset dominates
    step(1'b1, 1'b1, 7'h02, 16'hFFFF, 1'b1, 1'b0);
    step(1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 1'b0);
    chk("rst_drdy", 32'(drp_drdy), 32'h0);
    chk("rst_dout", 32'(drp_dout), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_reg0", 32'(cfg_o[15:0]), 32'(RVAL));
    idle();

    // Write A5C3 to addr 5: completion exactly three cycles after the request
    step(1'b1, 1'b1, 7'd5, 16'hA5C3, 1'b0, 1'b0);
    chk("w5_n1_drdy", 32'(drp_drdy), 32'h0);
    idle();
    chk("w5_n2_drdy", 32'(drp_drdy), 32'h0);
    idle();
    chk("w5_n3_drdy", 32'(drp_drdy), 32'h1);
    chk("w5_n3_strobe", 32'(wr_strobe_o), 32'h1);
    chk("w5_waddr", 32'(wr_addr_o), 32'd5);
    chk("w5_cfg", 32'(cfg_o[95:80]), 32'hA5C3);
    idle();
    chk("w5_n4_drdy", 32'(drp_drdy), 32'h0);

    // Read back addr 5, then status word
    step(1'b1, 1'b0, 7'd5, 16'h0, 1'b0, 1'b0); idle(); idle();
    chk("r5_dout", 32'(drp_dout), 32'hA5C3);
    drp_den = 1; drp_dwe = 0; drp_addr = 7'h7F; status_i = 16'h1234;
    @(posedge clk_usb); edge_no++; model_edge(); #1;
    idle(); idle();
    // status is sampled on the commit edge; the model saw the random value used then
    chk("r7f_model", 32'(drp_dout), 32'(m_dout));
    drp_den = 1; drp_dwe = 0; drp_addr = 7'h7F;
    @(posedge clk_usb); edge_no++; model_edge(); #1;
    drp_den = 0; reset_i = 0;
    @(posedge clk_usb); edge_no++; model_edge(); #1;
    status_i = 16'h1234;
    @(posedge clk_usb); edge_no++; model_edge(); #1;
    chk("r7f_dout", 32'(drp_dout), 32'h1234);
    idle();

    // Overlapping request is ignored and flagged
    step(1'b1, 1'b0, 7'd5, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 7'd6, 16'hFFFF, 1'b0, 1'b0);
    chk("ovl_err", 32'(err_o), 32'h1);
    idle();
    chk("ovl_drdy", 32'(drp_drdy), 32'h1);
    idle();
    chk("ovl_single", 32'(drp_drdy), 32'h0);
    chk("ovl_reg6", 32'(cfg_o[111:96]), 32'(RVAL));
    step(1'b0, 1'b0, 7'h0, 16'h0, 1'b0, 1'b1);
    chk("clr_err", 32'(err_o), 32'h0);

    // Out-of-range write and read
    step(1'b1, 1'b1, 7'd40, 16'hDEAD, 1'b0, 1'b0); idle(); idle();
    chk("bad_drdy", 32'(drp_drdy), 32'h1);
    chk("bad_strobe", 32'(wr_strobe_o), 32'h0);
    chk("bad_err", 32'(err_o), 32'h2);
    step(1'b1, 1'b0, 7'd40, 16'h0, 1'b0, 1'b0); idle(); idle();
    chk("bad_rd_dout", 32'(drp_dout), 32'h0);
    step(1'b0, 1'b0, 7'h0, 16'h0, 1'b0, 1'b1);

    // Request in the drdy cycle is accepted; next drdy three cycles later
    step(1'b1, 1'b1, 7'd3, 16'h1111, 1'b0, 1'b0); idle(); idle();
    chk("b2b_first", 32'(drp_drdy), 32'h1);
    step(1'b1, 1'b0, 7'd3, 16'h0, 1'b0, 1'b0);
    chk("b2b_gap", 32'(drp_drdy), 32'h0);
    idle(); idle();
    chk("b2b_second", 32'(drp_drdy), 32'h1);
    chk("b2b_dout", 32'(drp_dout), 32'h1111);

    // Reset one cycle after a write request aborts it
    step(1'b1, 1'b1, 7'd9, 16'h7777, 1'b0, 1'b0);
    step(1'b0, 1'b0, 7'h0, 16'h0, 1'b1, 1'b0);
    idle();
    chk("abort_drdy1", 32'(drp_drdy), 32'h0);
    idle();
    chk("abort_drdy2", 32'(drp_drdy), 32'h0);
    chk("abort_reg9", 32'(cfg_o[159:144]), 32'(RVAL));

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [6:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       a = 7'($urandom_range(0, 31));
      else if (sel < 8)  a = 7'h7F;
      else               a = 7'($urandom_range(32, 126));
      step(($urandom_range(0, 9) < 4), 1'($urandom), a, 16'($urandom),
           ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
